lfm_burst_sequencer: RTL and testbench

//  Burst scheduler for the dds_lfm chirp generator. On arm, issues N chirps at a fixed pulse repetition interval (PRI).

---
 rtl/lfm_burst_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_lfm_burst_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfm_burst_sequencer.sv
// lfm_burst_sequencer: schedules a stepped-frequency LFM burst on a dds_lfm chirp core.
// Rev 1.0
`default_nettype none

module lfm_burst_sequencer #(
  parameter int CNT_W     = 32,
  parameter int NP_W      = 16,
  parameter int TO_MARGIN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic             abort_i,
  input  logic [31:0]      cfg_f_start_i,
  input  logic [31:0]      cfg_f_stop_i,
  input  logic [31:0]      cfg_f_step_i,
  input  logic [31:0]      cfg_f_clk_i,
  input  logic [63:0]      cfg_chirp_len_i,
  input  logic [CNT_W-1:0] cfg_pri_i,
  input  logic [NP_W-1:0]  cfg_n_pulses_i,
  input  logic             dds_busy_i,
  input  logic             dds_done_i,
  output logic             dds_start_o,
  output logic [31:0]      dds_f_start_o,
  output logic [31:0]      dds_f_stop_o,
  output logic [31:0]      dds_f_clk_o,
  output logic [63:0]      dds_chirp_len_o,
  output logic             busy_o,
  output logic [NP_W-1:0]  pulse_idx_o,
  output logic             burst_done_o,
  output logic             aborted_o,
  output logic             pri_overrun_o,
  output logic             err_cfg_o,
  output logic             err_timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FIRE = 3'd1,
    S_WAIT = 3'd2,
    S_GAP  = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             abort_q, abort_d;
  logic [31:0]      f_start_q, f_start_d;
  logic [31:0]      f_stop_q, f_stop_d;
  logic [31:0]      step_q, step_d;
  logic [31:0]      f_clk_q, f_clk_d;
  logic [63:0]      len_q, len_d;
  logic [CNT_W-1:0] pri_q, pri_d;
  logic [NP_W-1:0]  np_q, np_d;
  logic [NP_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] pri_cnt_q, pri_cnt_d;
  logic [63:0]      to_cnt_q, to_cnt_d;
  logic             aborted_q, aborted_d;
  logic             ovr_q, ovr_d;
  logic             ecfg_q, ecfg_d;
  logic             eto_q, eto_d;

  logic             w_go_fire, w_advance;
  logic [CNT_W-1:0] w_pri_inc;
  logic [63:0]      w_to_inc;
  logic [64:0]      w_to_lim;
  logic             w_to_exp, w_cfg_ok, w_last, w_pri_end, w_abort;

  assign w_pri_inc = (pri_cnt_q == '1) ? pri_cnt_q : pri_cnt_q + CNT_W'(1);
  assign w_to_inc  = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + 64'd1;
  // 65-bit limit so a huge chirp_len cannot wrap the timeout threshold
  assign w_to_lim  = {1'b0, len_q} + 65'(TO_MARGIN);
  assign w_to_exp  = {1'b0, w_to_inc} > w_to_lim;
  assign w_cfg_ok  = (cfg_chirp_len_i != '0) && (cfg_n_pulses_i != '0) &&
                     (cfg_f_clk_i != '0) && (cfg_f_stop_i >= cfg_f_start_i) &&
                     (cfg_pri_i != '0);
  assign w_last    = (idx_q == np_q - NP_W'(1));
  assign w_pri_end = (pri_cnt_q >= pri_q - CNT_W'(1));
  assign w_abort   = abort_q | abort_i;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    abort_d   = abort_q;
    f_start_d = f_start_q;
    f_stop_d  = f_stop_q;
    step_d    = step_q;
    f_clk_d   = f_clk_q;
    len_d     = len_q;
    pri_d     = pri_q;
    np_d      = np_q;
    idx_d     = idx_q;
    pri_cnt_d = w_pri_inc;
    to_cnt_d  = w_to_inc;
    aborted_d = aborted_q;
    ovr_d     = ovr_q;
    ecfg_d    = ecfg_q;
    eto_d     = eto_q;
    w_go_fire = 1'b0;
    w_advance = 1'b0;

    if (state_q != S_IDLE && abort_i) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          f_start_d = cfg_f_start_i;
          f_stop_d  = cfg_f_stop_i;
          step_d    = cfg_f_step_i;
          f_clk_d   = cfg_f_clk_i;
          len_d     = cfg_chirp_len_i;
          pri_d     = cfg_pri_i;
          np_d      = cfg_n_pulses_i;
          idx_d     = '0;
          abort_d   = 1'b0;
          pend_d    = 1'b0;
          aborted_d = 1'b0;
          ovr_d     = 1'b0;
          ecfg_d    = 1'b0;
          eto_d     = 1'b0;
          if (!w_cfg_ok) begin
            ecfg_d  = 1'b1;
            state_d = S_END;
          end else if (dds_busy_i) begin
            pend_d = 1'b1;
          end else begin
            w_go_fire = 1'b1;
          end
        end else if (pend_q && !dds_busy_i) begin
          pend_d    = 1'b0;
          w_go_fire = 1'b1;
        end
      end
      S_FIRE: state_d = S_WAIT;
      S_WAIT: begin
        if (dds_done_i) begin
          if (w_pri_end) ovr_d = 1'b1;
          if (w_last || w_abort) begin
            aborted_d = aborted_q | w_abort;
            state_d   = S_END;
          end else if (w_pri_end) begin
            w_go_fire = 1'b1;
            w_advance = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else if (w_to_exp) begin
          eto_d     = 1'b1;
          aborted_d = aborted_q | w_abort;
          state_d   = S_END;
        end
      end
      S_GAP: begin
        if (w_abort) begin
          aborted_d = 1'b1;
          state_d   = S_END;
        end else if (w_pri_end) begin
          w_go_fire = 1'b1;
          w_advance = 1'b1;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counters read 0 in the FIRE cycle so that count == pri-1 lands one cycle before the next start
    if (w_go_fire) begin
      state_d   = S_FIRE;
      pri_cnt_d = '0;
      to_cnt_d  = '0;
    end
    if (w_advance) begin
      idx_d     = idx_q + NP_W'(1);
      f_start_d = f_start_q + step_q;
      f_stop_d  = f_stop_q + step_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      abort_q   <= 1'b0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      step_q    <= '0;
      f_clk_q   <= '0;
      len_q     <= '0;
      pri_q     <= '0;
      np_q      <= '0;
      idx_q     <= '0;
      pri_cnt_q <= '0;
      to_cnt_q  <= '0;
      aborted_q <= 1'b0;
      ovr_q     <= 1'b0;
      ecfg_q    <= 1'b0;
      eto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      abort_q   <= abort_d;
      f_start_q <= f_start_d;
      f_stop_q  <= f_stop_d;
      step_q    <= step_d;
      f_clk_q   <= f_clk_d;
      len_q     <= len_d;
      pri_q     <= pri_d;
      np_q      <= np_d;
      idx_q     <= idx_d;
      pri_cnt_q <= pri_cnt_d;
      to_cnt_q  <= to_cnt_d;
      aborted_q <= aborted_d;
      ovr_q     <= ovr_d;
      ecfg_q    <= ecfg_d;
      eto_q     <= eto_d;
    end
  end

  assign dds_start_o     = (state_q == S_FIRE);
  assign busy_o          = (state_q == S_FIRE) || (state_q == S_WAIT) || (state_q == S_GAP);
  assign burst_done_o    = (state_q == S_END);
  assign dds_f_start_o   = f_start_q;
  assign dds_f_stop_o    = f_stop_q;
  assign dds_f_clk_o     = f_clk_q;
  assign dds_chirp_len_o = len_q;
  assign pulse_idx_o     = idx_q;
  assign aborted_o       = aborted_q;
  assign pri_overrun_o   = ovr_q;
  assign err_cfg_o       = ecfg_q;
  assign err_timeout_o   = eto_q;

endmodule

`default_nettype wire

// File: tb/tb_lfm_burst_sequencer.sv
// tb_lfm_burst_sequencer: directed bursts against a simple DDS model, scoreboard-checked.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_lfm_burst_sequencer;
  localparam int CNT_W = 32;
  localparam int NP_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, abort_s = 1'b0;
  logic [31:0] c_fs = '0, c_fe = '0, c_step = '0, c_fc = '0;
  logic [63:0] c_len = '0;
  logic [CNT_W-1:0] c_pri = '0;
  logic [NP_W-1:0] c_np = '0;
  logic dds_busy, dds_done;
  logic dds_start, busy, burst_done, aborted, pri_overrun, err_cfg, err_timeout;
  logic [31:0] dds_f_start, dds_f_stop, dds_f_clk;
  logic [63:0] dds_chirp_len;
  logic [NP_W-1:0] pulse_idx;

  lfm_burst_sequencer #(.CNT_W(CNT_W), .NP_W(NP_W), .TO_MARGIN(16)) dut (
    .clk(clk), .rst(rst), .arm_i(arm), .abort_i(abort_s),
    .cfg_f_start_i(c_fs), .cfg_f_stop_i(c_fe), .cfg_f_step_i(c_step), .cfg_f_clk_i(c_fc),
    .cfg_chirp_len_i(c_len), .cfg_pri_i(c_pri), .cfg_n_pulses_i(c_np),
    .dds_busy_i(dds_busy), .dds_done_i(dds_done),
    .dds_start_o(dds_start), .dds_f_start_o(dds_f_start), .dds_f_stop_o(dds_f_stop),
    .dds_f_clk_o(dds_f_clk), .dds_chirp_len_o(dds_chirp_len), .busy_o(busy),
    .pulse_idx_o(pulse_idx), .burst_done_o(burst_done), .aborted_o(aborted),
    .pri_overrun_o(pri_overrun), .err_cfg_o(err_cfg), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DDS model: busy for chirp_len-1 cycles after start, done in cycle start+chirp_len
  logic        m_act = 1'b0;
  logic [63:0] m_cnt = '0;
  logic        suppress_done = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_cnt <= '0;
    end else if (dds_start) begin
      m_act <= 1'b1;
      m_cnt <= 64'd1;
    end else if (m_act) begin
      if (m_cnt >= dds_chirp_len) m_act <= 1'b0;
      else m_cnt <= m_cnt + 64'd1;
    end
  end
  assign dds_done = m_act && (m_cnt == dds_chirp_len) && !suppress_done;
  assign dds_busy = m_act && (m_cnt < dds_chirp_len);

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [31:0] fs, fe, fc;
    logic [63:0] len;
    logic [15:0] idx;
    logic [3:0]  flg;   // {aborted, pri_overrun, err_cfg, err_timeout}
  } exp_t;

  exp_t q[$];
  exp_t e;
  int n_vec = 0, n_bad = 0;

  task automatic push_start(input int c, input logic [31:0] fs, input logic [31:0] fe,
                            input logic [15:0] idx);
    exp_t x;
    x.is_done = 1'b0; x.cyc = c; x.fs = fs; x.fe = fe; x.fc = c_fc; x.len = c_len;
    x.idx = idx; x.flg = '0;
    q.push_back(x);
  endtask

  task automatic push_done(input int c, input logic [15:0] idx, input logic [3:0] flg);
    exp_t x;
    x.is_done = 1'b1; x.cyc = c; x.fs = '0; x.fe = '0; x.fc = '0; x.len = '0;
    x.idx = idx; x.flg = flg;
    q.push_back(x);
  endtask

  // Monitor: every dds_start or burst_done must match the head of the queue
  always @(negedge clk) begin
    if (!rst && (dds_start || burst_done)) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d dds_start=%0b burst_done=%0b", cyc, dds_start, burst_done);
      end else begin
        e = q.pop_front();
        if (!e.is_done) begin
          if (!(dds_start && cyc == e.cyc && dds_f_start == e.fs && dds_f_stop == e.fe &&
                dds_f_clk == e.fc && dds_chirp_len == e.len && pulse_idx == e.idx && busy)) begin
            n_bad++;
            $display("FAIL dds_start got cyc=%0d start=%0b fs=%0d fe=%0d fc=%0d len=%0d idx=%0d busy=%0b, want cyc=%0d start=1 fs=%0d fe=%0d fc=%0d len=%0d idx=%0d busy=1",
                     cyc, dds_start, dds_f_start, dds_f_stop, dds_f_clk, dds_chirp_len, pulse_idx, busy,
                     e.cyc, e.fs, e.fe, e.fc, e.len, e.idx);
          end
        end else begin
          if (!(burst_done && cyc == e.cyc && pulse_idx == e.idx && !busy &&
                {aborted, pri_overrun, err_cfg, err_timeout} == e.flg)) begin
            n_bad++;
            $display("FAIL burst_done got cyc=%0d done=%0b idx=%0d busy=%0b flags=%b, want cyc=%0d done=1 idx=%0d busy=0 flags=%b",
                     cyc, burst_done, pulse_idx, busy, {aborted, pri_overrun, err_cfg, err_timeout},
                     e.cyc, e.idx, e.flg);
          end
        end
      end
    end
  end

  task automatic sync(output int t);
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s pending_events=%0d after %0d cycles, want 0", name, q.size(), budget);
      q.delete();
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic check_all_zero(input string name);
    n_vec++;
    if (|{dds_start, dds_f_start, dds_f_stop, dds_f_clk, dds_chirp_len, busy, pulse_idx,
          burst_done, aborted, pri_overrun, err_cfg, err_timeout}) begin
      n_bad++;
      $display("FAIL %s outputs not zero: start=%0b fs=%0d fe=%0d fc=%0d len=%0d busy=%0b idx=%0d done=%0b flags=%b",
               name, dds_start, dds_f_start, dds_f_stop, dds_f_clk, dds_chirp_len, busy, pulse_idx,
               burst_done, {aborted, pri_overrun, err_cfg, err_timeout});
    end
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [63:0] len,
                         input logic [31:0] pri, input logic [15:0] np);
    c_fs = fs; c_fe = fe; c_step = 32'd500; c_fc = 32'd100_000_000;
    c_len = len; c_pri = pri; c_np = np;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    #12;
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // 1: nominal three-pulse stepped burst
    set_cfg(32'd1000, 32'd2000, 64'd100, 32'd200, 16'd3);
    sync(t);
    push_start(t + 1,   32'd1000, 32'd2000, 16'd0);
    push_start(t + 201, 32'd1500, 32'd2500, 16'd1);
    push_start(t + 401, 32'd2000, 32'd3000, 16'd2);
    push_done(t + 502, 16'd2, 4'b0000);
    pulse_arm();
    drain("nominal_burst", 1000);

    // 2: chirp longer than PRI
    set_cfg(32'd1000, 32'd2000, 64'd300, 32'd200, 16'd2);
    sync(t);
    push_start(t + 1,   32'd1000, 32'd2000, 16'd0);
    push_start(t + 302, 32'd1500, 32'd2500, 16'd1);
    push_done(t + 603, 16'd1, 4'b0100);
    pulse_arm();
    drain("pri_overrun", 1000);

    // 3a: zero chirp length rejected
    set_cfg(32'd1000, 32'd2000, 64'd0, 32'd200, 16'd2);
    sync(t);
    push_done(t + 1, 16'd0, 4'b0010);
    pulse_arm();
    drain("cfg_len_zero", 50);

    // 3b: stop below start rejected
    set_cfg(32'd3000, 32'd2000, 64'd100, 32'd200, 16'd2);
    sync(t);
    push_done(t + 1, 16'd0, 4'b0010);
    pulse_arm();
    drain("cfg_stop_lt_start", 50);

    // 4: abort during second chirp of five
    set_cfg(32'd1000, 32'd2000, 64'd100, 32'd200, 16'd5);
    sync(t);
    push_start(t + 1,   32'd1000, 32'd2000, 16'd0);
    push_start(t + 201, 32'd1500, 32'd2500, 16'd1);
    push_done(t + 302, 16'd1, 4'b1000);
    pulse_arm();
    while (cyc < t + 250) @(posedge clk);
    #1;
    abort_s = 1'b1;
    @(posedge clk);
    #1;
    abort_s = 1'b0;
    drain("abort_mid_burst", 1000);

    // 5: DDS never reports done
    suppress_done = 1'b1;
    set_cfg(32'd1000, 32'd2000, 64'd50, 32'd200, 16'd2);
    sync(t);
    push_start(t + 1, 32'd1000, 32'd2000, 16'd0);
    push_done(t + 68, 16'd0, 4'b0001);
    pulse_arm();
    drain("dds_timeout", 500);
    suppress_done = 1'b0;

    // 6: reset in the gap, then a fresh burst
    set_cfg(32'd1000, 32'd2000, 64'd100, 32'd200, 16'd3);
    sync(t);
    push_start(t + 1, 32'd1000, 32'd2000, 16'd0);
    pulse_arm();
    while (cyc < t + 150) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_all_zero("reset_mid_gap_immediate");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_mid_gap_held");
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pre_reset_events pending=%0d, want 0", q.size());
      q.delete();
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    set_cfg(32'd5000, 32'd6000, 64'd100, 32'd200, 16'd1);
    sync(t);
    push_start(t + 1, 32'd5000, 32'd6000, 16'd0);
    push_done(t + 102, 16'd0, 4'b0000);
    pulse_arm();
    drain("rearm_after_reset", 500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
